// File: rtl/osd_stm_package.sv
// osd_stm_package: shared widths and event type for the STM trace path
//   STM_TRACE_ID_W / DROP_CNT_W : trace id and drop counter widths
//   trace_event_t               : one trace event (id, value) at the STM's native 64-bit value width
package osd_stm_package;
    localparam int STM_TRACE_ID_W = 16;
    localparam int DROP_CNT_W     = 16;
    localparam int STM_VALWIDTH   = 64;
    typedef struct packed {
        logic [STM_TRACE_ID_W-1:0] id;
        logic [STM_VALWIDTH-1:0]   value;
    } trace_event_t;
endpackage

// File: rtl/osd_rr_arbiter.sv
// osd_rr_arbiter: round-robin arbiter with an internal last-grant pointer
//   clk, rst  : clock, synchronous active-high reset (pointer -> N-1, so index 0 wins first)
//   req       : request vector
//   advance   : move the pointer to the current winner (only if a request exists)
//   grant     : one-hot winner, searched from last+1 with wrap
//   grant_idx : binary index of the winner (0 when nothing requests)
module osd_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] last, idx;
    logic [IW:0]   sum;
    logic          found;

    // sum holds last+k before the modulo-N wrap, one bit wider so 2N-1 fits
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last} + (IW+1)'(k);
            idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

    always_ff @(posedge clk)
        if (rst) last <= IW'(N - 1);
        else if (advance && |req) last <= grant_idx;
endmodule

// File: rtl/osd_stm_trace_arbiter.sv
// osd_stm_trace_arbiter: merges NUM_SRC fire-and-forget trace sources onto one STM trace port
//   clk, rst                          : clock, synchronous active-high reset
//   src_enable/src_valid              : per-source static enable and one-cycle event strobe
//   src_id/src_value                  : packed per-source id (16b) and value (VALWIDTH)
//   trace_valid/id/value/src          : registered event to the STM and its source index
//   drop_count/drop_clear             : saturating count of discarded events, synchronous clear
module osd_stm_trace_arbiter
    import osd_stm_package::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int VALWIDTH = 64,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  src_enable,
    input  logic [NUM_SRC-1:0]                  src_valid,
    input  logic [NUM_SRC*STM_TRACE_ID_W-1:0]   src_id,
    input  logic [NUM_SRC*VALWIDTH-1:0]         src_value,
    output logic                                trace_valid,
    output logic [STM_TRACE_ID_W-1:0]           trace_id,
    output logic [VALWIDTH-1:0]                 trace_value,
    output logic [SRC_W-1:0]                    trace_src,
    output logic [DROP_CNT_W-1:0]               drop_count,
    input  logic                                drop_clear
);
    localparam int CW = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0]        pend, grant, load, drop_inc;
    logic [SRC_W-1:0]          grant_idx;
    logic [STM_TRACE_ID_W-1:0] slot_id    [NUM_SRC];
    logic [VALWIDTH-1:0]       slot_value [NUM_SRC];
    logic [CW-1:0]             drops;
    logic [DROP_CNT_W:0]       drop_sum;

    osd_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend & src_enable),
        .advance   (1'b1),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // a slot being granted this cycle is free to take a new event, so that is not a drop
    assign load     = src_enable & src_valid & (~pend | grant);
    assign drop_inc = src_enable & src_valid & pend & ~grant;

    always_comb begin
        drops = '0;
        for (int i = 0; i < NUM_SRC; i++)
            drops = drops + CW'(drop_inc[i]);
        drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(drops);
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NUM_SRC; i++)
            if (rst || !src_enable[i]) pend[i] <= 1'b0;
            else if (load[i]) pend[i] <= 1'b1;
            else if (grant[i]) pend[i] <= 1'b0;

    // slot payload is only observed while pend is set, so it needs no reset
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_SRC; i++)
            if (load[i]) begin
                slot_id[i]    <= src_id[STM_TRACE_ID_W*i +: STM_TRACE_ID_W];
                slot_value[i] <= src_value[VALWIDTH*i +: VALWIDTH];
            end

    always_ff @(posedge clk)
        if (rst) begin
            trace_valid <= 1'b0;
            trace_id    <= '0;
            trace_value <= '0;
            trace_src   <= '0;
        end else begin
            trace_valid <= |grant;
            if (|grant) begin
                trace_id    <= slot_id[grant_idx];
                trace_value <= slot_value[grant_idx];
                trace_src   <= grant_idx;
            end
        end

    always_ff @(posedge clk)
        if (rst || drop_clear) drop_count <= '0;
        else drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
endmodule

// File: tb/tb_osd_stm_trace_arbiter.sv
// tb_osd_stm_trace_arbiter: directed self-checking bench for osd_stm_trace_arbiter
module tb_osd_stm_trace_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_enable = '1;
    logic [N-1:0]    src_valid = '0;
    logic [N*16-1:0] src_id = '0;
    logic [N*64-1:0] src_value = '0;
    logic            trace_valid;
    logic [15:0]     trace_id;
    logic [63:0]     trace_value;
    logic [1:0]      trace_src;
    logic [15:0]     drop_count;
    logic            drop_clear = 1'b0;
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clk = ~clk;

    osd_stm_trace_arbiter #(.NUM_SRC(N), .VALWIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_enable  (src_enable),
        .src_valid   (src_valid),
        .src_id      (src_id),
        .src_value   (src_value),
        .trace_valid (trace_valid),
        .trace_id    (trace_id),
        .trace_value (trace_value),
        .trace_src   (trace_src),
        .drop_count  (drop_count),
        .drop_clear  (drop_clear)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0;
        drop_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put(input int s, input logic [15:0] id, input logic [63:0] v);
        src_valid[s] = 1'b1;
        src_id[16*s +: 16] = id;
        src_value[64*s +: 64] = v;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 64'(trace_valid), 0);
        check("rst_id", 64'(trace_id), 0);
        check("rst_value", trace_value, 0);
        check("rst_src", 64'(trace_src), 0);
        check("rst_drop", 64'(drop_count), 0);

        put(2, 16'h0042, 64'hDEAD_BEEF);
        tick();
        src_valid = '0;
        check("single_lat1", 64'(trace_valid), 0);
        tick();
        check("single_valid", 64'(trace_valid), 1);
        check("single_id", 64'(trace_id), 64'h42);
        check("single_value", trace_value, 64'hDEAD_BEEF);
        check("single_src", 64'(trace_src), 2);
        check("single_drop", 64'(drop_count), 0);
        tick();
        check("single_end", 64'(trace_valid), 0);
        check("single_hold_id", 64'(trace_id), 64'h42);

        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < N; s++) put(s, 16'(16'h0100 * (b + 1) + s), 64'(s));
            tick();
            src_valid = '0;
            check("fair_load", 64'(trace_valid), 0);
            for (int k = 0; k < N; k++) begin
                tick();
                check("fair_valid", 64'(trace_valid), 1);
                check("fair_src", 64'(trace_src), 64'(k));
                check("fair_id", 64'(trace_id), 64'(16'h0100 * (b + 1) + k));
            end
        end
        tick();
        check("fair_end", 64'(trace_valid), 0);
        check("fair_drop", 64'(drop_count), 0);

        do_reset();
        for (int c = 0; c < 10; c++) begin
            put(0, 16'(c), 64'(c));
            put(1, 16'(256 + c), 64'(c));
            tick();
            check("cont_drop", 64'(drop_count), 64'(c));
            if (c == 0) check("cont_first", 64'(trace_valid), 0);
            else begin
                check("cont_valid", 64'(trace_valid), 1);
                check("cont_src", 64'(trace_src), 64'((c % 2 == 1) ? 0 : 1));
                check("cont_id", 64'(trace_id), 64'(((c % 2 == 1) ? 0 : 256) + ((c == 1) ? 0 : c - 2)));
            end
        end
        src_valid = '0;
        tick();
        check("cont_tail1_src", 64'(trace_src), 1);
        check("cont_tail1_id", 64'(trace_id), 64'(256 + 8));
        tick();
        check("cont_tail2_src", 64'(trace_src), 0);
        check("cont_tail2_id", 64'(trace_id), 64'(9));
        tick();
        check("cont_idle", 64'(trace_valid), 0);
        check("cont_drop_total", 64'(drop_count), 9);

        do_reset();
        for (int c = 0; c < 20; c++) begin
            put(0, 16'(16'h0300 + c), 64'(c));
            tick();
            if (c > 0) begin
                check("reload_valid", 64'(trace_valid), 1);
                check("reload_id", 64'(trace_id), 64'(16'h0300 + c - 1));
            end
        end
        src_valid = '0;
        tick();
        check("reload_last", 64'(trace_id), 64'h0313);
        check("reload_last_valid", 64'(trace_valid), 1);
        tick();
        check("reload_idle", 64'(trace_valid), 0);
        check("reload_drop", 64'(drop_count), 0);

        do_reset();
        src_enable = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            put(3, 16'(16'h0500 + c), 64'(c));
            tick();
            check("dis_valid", 64'(trace_valid), 0);
        end
        src_valid = '0;
        tick();
        check("dis_valid2", 64'(trace_valid), 0);
        check("dis_drop", 64'(drop_count), 0);
        src_enable = '1;
        tick();
        tick();
        check("dis_no_stale", 64'(trace_valid), 0);
        put(3, 16'h0333, 64'h3);
        tick();
        src_valid = '0;
        tick();
        check("reen_valid", 64'(trace_valid), 1);
        check("reen_src", 64'(trace_src), 3);
        check("reen_id", 64'(trace_id), 64'h0333);

        do_reset();
        src_valid = '1;
        for (int c = 0; c < 23400; c++) begin
            tick();
            if (c == 9) check("sat_multi_inc", 64'(drop_count), 27);
            if (c == 21844) check("sat_below", 64'(drop_count), 64'hFFFC);
            if (c == 21845) check("sat_reach", 64'(drop_count), 64'hFFFF);
        end
        check("sat_hold", 64'(drop_count), 64'hFFFF);
        check("sat_valid", 64'(trace_valid), 1);
        tick();
        tick();
        check("sat_hold2", 64'(drop_count), 64'hFFFF);
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        check("clr_override", 64'(drop_count), 0);
        tick();
        check("clr_resume", 64'(drop_count), 3);
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(trace_valid), 0);
        check("midrst_id", 64'(trace_id), 0);
        check("midrst_src", 64'(trace_src), 0);
        check("midrst_drop", 64'(drop_count), 0);
        rst = 1'b0;
        src_valid = '0;
        tick();
        check("midrst_no_stale1", 64'(trace_valid), 0);
        tick();
        check("midrst_no_stale2", 64'(trace_valid), 0);
        check("midrst_drop2", 64'(drop_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/osd_stm_trace_arbiter.md
Name: osd_stm_trace_arbiter

Overview:
Shares the single system-trace-macrocell trace port (trace_valid/trace_id/trace_value) between NUM_SRC fire-and-forget trace sources, e.g. several cores.
- Each source has one holding slot.
- A round-robin scheduler forwards at most one event per cycle into the STM.
- Events are dropped only when a slot is still occupied; drops are counted for debug-host readout.
- Sits directly in front of the STM trace input inside the debug subsystem.

Parameters:
NUM_SRC, 4, number of trace sources (2..16)
VALWIDTH, 64, trace value width; must equal the downstream STM VALWIDTH
SRC_W, $clog2(NUM_SRC), width of the source index (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
src_enable  in  NUM_SRC  per-source enable, static configuration
src_valid  in  NUM_SRC  per-source event strobe, one cycle per event, no backpressure
src_id  in  NUM_SRC*16  packed trace ids; source i occupies bits [16*i +: 16]
src_value  in  NUM_SRC*VALWIDTH  packed values; source i occupies bits [VALWIDTH*i +: VALWIDTH]
trace_valid  out  1  registered event strobe to the STM
trace_id  out  16  registered trace id
trace_value  out  VALWIDTH  registered trace value
trace_src  out  SRC_W  index of the source that produced the current output event
drop_count  out  16  saturating count of dropped events, all sources combined
drop_clear  in  1  synchronous clear of drop_count

Behaviour:
- Reset values:
  - trace_valid=0, trace_id=0, trace_value=0, trace_src=0, drop_count=0.
  - All slots are empty.
  - Last-grant pointer = NUM_SRC-1, so source 0 has first priority.
- Per-source slot holds: pend (1 bit), id (16 bits), value (VALWIDTH bits).
- Slot update, per cycle, per source i, in priority order:
  - src_enable[i]=0: pend<=0; src_valid[i] ignored; nothing counted.
  - src_valid[i]=1 and (pend[i]=0 or grant[i]=1): load id/value and set pend<=1. A grant and a reload in the same cycle is NOT a drop.
  - src_valid[i]=1, pend[i]=1, grant[i]=0: incoming event discarded, slot keeps the old event, drop_inc.
  - else if grant[i]=1: pend<=0.
- Arbitration (combinational over pend & src_enable):
  - Round-robin search starts at last_grant+1 (mod NUM_SRC) and wraps.
  - At most one grant per cycle.
  - On grant: last_grant<=i, and output registers load slot i with trace_valid<=1, trace_src<=i.
  - No grant: trace_valid<=0; id/value/src hold their previous values.
- Latency: src_valid in cycle t → trace_valid in cycle t+2 when uncontended.
  - Every pending enabled source is served within NUM_SRC cycles of becoming pending.
- Throughput: one event per cycle aggregate. The STM has no backpressure toward this block (its own stall handling is internal).
- Drop counting:
  - drop_count increments by the number of drop_inc events in the cycle (0..NUM_SRC).
  - It saturates at 16'hFFFF and never wraps.
  - drop_clear=1 sets the count to 0 and overrides any increments in that cycle.
- Only one source enabled: behaves as a 2-cycle register pipe, with a drop only when src_valid arrives on consecutive cycles while the slot is not yet granted (never, since the slot is granted every cycle it is pending).
- Reset asserted mid-operation: all pending events are lost, no drops are counted, outputs return to reset values on the next edge.

Decomposition:
- Shared package osd_stm_package:
  - typedef trace_event_t (id[15:0], value[VALWIDTH-1:0]), parameterised by convention with VALWIDTH=64.
  - localparam STM_TRACE_ID_W=16.
  - localparam DROP_CNT_W=16.
- One natural sub-module: osd_rr_arbiter #(N).
  - Inputs: req[N], advance.
  - Outputs: one-hot grant[N], grant_idx.
  - Holds the last-grant pointer internally, reset to N-1, updated only when advance=1 and a request exists.

Test Plan:
- Single event: enable=4'hF, src_valid[2]=1 with id=16'h0042, value=64'hDEAD_BEEF at cycle 5 → trace_valid=1 at cycle 7, trace_id=16'h0042, trace_src=2, drop_count=0.
- Fairness: all four sources strobe together at cycle 3 → outputs in cycles 5,6,7,8 with trace_src 0,1,2,3; a second all-source burst starting at cycle 9 restarts the order at 0.
- Drop on contention: sources 0 and 1 strobe every cycle for 10 cycles → exactly one event output per cycle, alternating 0,1, drop_count nonzero; each drop increments by 1 and the total equals strobes minus outputs minus events still pending.
- Grant plus reload: source 0 alone, strobing every cycle for 20 cycles → 20 outputs with consecutive ids, drop_count=0.
- Disabled source: src_enable[3]=0, source 3 strobes 5 times → no output with trace_src=3, drop_count unchanged; re-enabling it yields output only for events arriving after enable.
- Saturation and clear: force 70000 drops → drop_count=16'hFFFF and holds; drop_clear for one cycle concurrent with a drop → drop_count=0 next cycle; then rst mid-burst → trace_valid=0 on the next cycle and no stale events emitted.
